// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC accumulator slice.
package mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Width needed to hold n products of two width-bit operands without loss.
  function automatic int acc_w(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

endpackage

// File: rtl/multiplier_cla.sv
// Combinational unsigned multiplier: shifted partial products summed with a
// generate/propagate carry-lookahead adder.
module multiplier_cla #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8
) (
  input  logic [A_WIDTH-1:0]         multicand,
  input  logic [B_WIDTH-1:0]         multiplier,
  output logic [A_WIDTH+B_WIDTH-1:0] product
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  function automatic logic [P_WIDTH-1:0] cla_add(input logic [P_WIDTH-1:0] a,
                                                 input logic [P_WIDTH-1:0] b);
    logic [P_WIDTH-1:0] g;
    logic [P_WIDTH-1:0] p;
    logic [P_WIDTH-1:0] c;
    g = a & b;
    p = a ^ b;
    c = '0;
    for (int i = 0; i < P_WIDTH - 1; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return p ^ c;
  endfunction

  logic [P_WIDTH-1:0] partial;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    partial = '0;
    for (int i = 0; i < B_WIDTH; i++) begin
      if (multiplier[i]) begin
        partial = cla_add(partial, P_WIDTH'(multicand) << i);
      end
    end
    product = partial;
  end

endmodule

// File: rtl/mac_accumulator.sv
// Multiply-accumulate stage: multiplies operand pairs, sums N_TERMS registered
// products and hands the sum downstream over valid/ready.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N_TERMS   = 4,
  parameter int ACC_WIDTH = acc_w(WIDTH, N_TERMS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 overflow
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int CNT_W  = $clog2(N_TERMS + 1);
  localparam int SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(N_TERMS);
  localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(N_TERMS - 1);

  state_t               state;
  state_t               state_next;
  logic [PROD_W-1:0]    product;
  logic [PROD_W-1:0]    prod_q;
  logic                 prod_v;
  logic [CNT_W-1:0]     cnt_in;
  logic [CNT_W-1:0]     cnt_acc;
  logic [ACC_WIDTH-1:0] acc;
  logic [SUM_W-1:0]     sum;
  logic                 accept;
  logic                 take;

  multiplier_cla #(
    .A_WIDTH(WIDTH),
    .B_WIDTH(WIDTH)
  ) u_mult (
    .multicand (multicand),
    .multiplier(multiplier),
    .product   (product)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    take       = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = rst_n && !clear && (cnt_in < LAST);
        if (prod_v && (cnt_acc == LAST_M1)) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        take      = out_ready;
        if (out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  assign accept  = in_valid && in_ready;
  assign sum     = SUM_W'(acc) + SUM_W'(prod_q);
  assign acc_out = acc;

  // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state    <= ACCUM;
      acc      <= '0;
      prod_v   <= 1'b0;
      cnt_in   <= '0;
      cnt_acc  <= '0;
      overflow <= 1'b0;
    end else begin
      state  <= state_next;
      prod_v <= accept;
      if (take) begin
        acc      <= '0;
        overflow <= 1'b0;
        cnt_in   <= '0;
        cnt_acc  <= '0;
      end else begin
        if (accept) cnt_in <= cnt_in + 1'b1;
        if (prod_v) begin
          acc     <= sum[ACC_WIDTH-1:0];
          cnt_acc <= cnt_acc + 1'b1;
          if (|sum[SUM_W-1:ACC_WIDTH]) overflow <= 1'b1;
        end
      end
    end
  end

  // NOTE: prod_q is pure datapath qualified by prod_v, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) prod_q <= product;
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: directed scenarios plus randomized traffic, two
// instances (18-bit and 16-bit accumulators) checked against one arithmetic model.
module tb_mac_accumulator;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [7:0]  multicand;
  logic [7:0]  multiplier;
  logic        out_ready;

  logic        in_ready18, out_valid18, overflow18;
  logic [17:0] acc18;
  logic        in_ready16, out_valid16, overflow16;
  logic [15:0] acc16;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  mac_accumulator #(.WIDTH(8), .N_TERMS(N), .ACC_WIDTH(18)) u_dut18 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready18),
    .multicand(multicand), .multiplier(multiplier), .out_valid(out_valid18),
    .out_ready(out_ready), .acc_out(acc18), .overflow(overflow18)
  );

  mac_accumulator #(.WIDTH(8), .N_TERMS(N), .ACC_WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready16),
    .multicand(multicand), .multiplier(multiplier), .out_valid(out_valid16),
    .out_ready(out_ready), .acc_out(acc16), .overflow(overflow16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Reference model: the true (unbounded) running sum of the current result,
  // the product in flight, and how many terms have been accepted and added.
  longint m_sum = 0;
  longint m_pend = 0;
  bit     m_pend_v = 1'b0;
  bit     m_done = 1'b0;
  int     m_cnt_in = 0;
  int     m_added = 0;

  function automatic bit exp_ready();
    return rst_n && !clear && !m_done && (m_cnt_in < N);
  endfunction

  always @(posedge clk) begin
    longint s;
    bit     d;
    int     cnt;
    int     added;
    bit     rdy;
    rdy = exp_ready();
    if (!rst_n || clear) begin
      m_sum = 0; m_pend_v = 0; m_done = 0; m_cnt_in = 0; m_added = 0;
    end else begin
      s = m_sum; d = m_done; cnt = m_cnt_in; added = m_added;
      if (m_pend_v) begin
        s += m_pend;
        added++;
        if (added == N) d = 1'b1;
      end
      if (m_done && out_ready) begin
        s = 0; d = 1'b0; cnt = 0; added = 0;
      end
      if (in_valid && rdy) begin
        m_pend   = longint'(multicand) * longint'(multiplier);
        m_pend_v = 1'b1;
        cnt++;
      end else begin
        m_pend_v = 1'b0;
      end
      m_sum = s; m_done = d; m_cnt_in = cnt; m_added = added;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("in_ready18",  in_ready18,  exp_ready());
      check("in_ready16",  in_ready16,  exp_ready());
      check("out_valid18", out_valid18, m_done);
      check("out_valid16", out_valid16, m_done);
      check("acc18",       acc18,       64'(m_sum[17:0]));
      check("acc16",       acc16,       64'(m_sum[15:0]));
      check("overflow18",  overflow18,  (m_sum >= 64'd262144));
      check("overflow16",  overflow16,  (m_sum >= 64'd65536));
    end
  end

  // Caller is just after a rising edge; returns just after the accepting edge.
  task automatic send_pair(input int ma, input int mb, input int gap);
    bit done_f = 1'b0;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    multicand  = 8'(ma);
    multiplier = 8'(mb);
    in_valid   = 1'b1;
    for (int i = 0; i < 50 && !done_f; i++) begin
      @(negedge clk);
      if (in_ready18) begin
        @(posedge clk);
        #1;
        done_f = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done_f) fail_timeout("send_pair");
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid18;
    end
    if (!seen) fail_timeout(name);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit took;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    multicand = '0; multiplier = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready18, 0);
    check("rst_out_valid", out_valid18, 0);
    check("rst_acc", acc18, 0);
    check("rst_overflow", overflow18, 0);
    check_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready18, 1);
    @(posedge clk); #1;

    // Back-to-back pairs, consumer always ready.
    out_ready = 1'b1;
    send_pair(165, 15, 0); send_pair(10, 3, 0); send_pair(2, 1, 0); send_pair(255, 255, 0);
    @(negedge clk);
    check("s1_valid_edge_k1", out_valid18, 0);
    @(negedge clk);
    check("s1_valid_edge_k2", out_valid18, 1);
    check("s1_acc", acc18, 67532);
    check("s1_overflow", overflow18, 0);
    check("s1_model_sum", m_sum, 67532);
    @(negedge clk);
    check("s1_valid_one_cycle", out_valid18, 0);
    @(posedge clk); #1;

    // Same pairs with random gaps.
    send_pair(165, 15, $urandom_range(3)); send_pair(10, 3, $urandom_range(3));
    send_pair(2, 1, $urandom_range(3));    send_pair(255, 255, $urandom_range(3));
    wait_valid("s2_wait");
    check("s2_acc", acc18, 67532);
    @(posedge clk); #1;

    // Consumer stalls in DONE.
    out_ready = 1'b0;
    send_pair(165, 15, 0); send_pair(10, 3, 0); send_pair(2, 1, 0); send_pair(255, 255, 0);
    wait_valid("s3_wait");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("s3_hold_valid", out_valid18, 1);
      check("s3_hold_acc", acc18, 67532);
      check("s3_hold_ready", in_ready18, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("s3_taken_acc", acc18, 0);
    check("s3_taken_ready", in_ready18, 1);
    @(posedge clk); #1;

    // Wrap of the 16-bit accumulator, then reset while in DONE.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_pair(255, 255, 0);
    wait_valid("s4_wait");
    check("s4_acc16", acc16, 63492);
    check("s4_ovf16", overflow16, 1);
    check("s4_acc18", acc18, 260100);
    check("s4_ovf18", overflow18, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("s6_ready_in_reset", in_ready18, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("s6_out_valid", out_valid18, 0);
    check("s6_acc", acc16, 0);
    check("s6_ovf16", overflow16, 0);
    check("s6_ready", in_ready18, 1);
    @(posedge clk); #1;

    // Clear mid-sum drops partial work and the pair presented with it.
    out_ready = 1'b1;
    send_pair(7, 9, 0); send_pair(3, 4, 0);
    clear = 1'b1; in_valid = 1'b1; multicand = 8'd200; multiplier = 8'd200;
    @(negedge clk);
    check("s5_clear_ready", in_ready18, 0);
    @(posedge clk); #1 clear = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) send_pair(1, 1, 0);
    wait_valid("s5_wait");
    check("s5_acc", acc18, 4);
    check("s5_ovf", overflow18, 0);
    @(posedge clk); #1;

    // Randomized traffic: held data on stall, random consumer, occasional clear.
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      took = in_valid && in_ready18;
      @(posedge clk); #1;
      if (took || !in_valid) begin
        in_valid   = ($urandom_range(3) != 0);
        multicand  = 8'($urandom);
        multiplier = 8'($urandom);
      end
      out_ready = ($urandom_range(1) != 0);
      clear     = ($urandom_range(49) == 0);
    end
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
